// File: rtl/issue_cmd_arbiter_pkg.sv
// Shared command types and the round-robin helper for the issue command arbiter.
// The bench uses rr_pick as well, so the grant order is defined in one place.
package issue_cmd_arbiter_pkg;

    localparam int unsigned BA_BITS   = 3;
    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned MAX_BANKS = 1 << BA_BITS;

    typedef enum logic [2:0] {
        ATCMD_NOP       = 3'd0,
        ATCMD_ACTIVE    = 3'd1,
        ATCMD_READ      = 3'd2,
        ATCMD_WRITE     = 3'd3,
        ATCMD_PRECHARGE = 3'd4,
        ATCMD_REFRESH   = 3'd5
    } sch_cmd_t;

    typedef struct packed {
        sch_cmd_t               command;
        logic [ADDR_BITS-1:0]   addr;
        logic [BA_BITS-1:0]     bank;
    } issue_fifo_cmd_in_t;

    localparam int unsigned ISSUE_CMD_W = $bits(issue_fifo_cmd_in_t);

    typedef struct packed {
        logic               found;
        logic [BA_BITS-1:0] idx;
    } rr_pick_t;

    // First set bit at or after ptr, wrapping at num_banks (num_banks <= MAX_BANKS, ptr < num_banks).
    function automatic rr_pick_t rr_pick(input logic [MAX_BANKS-1:0] valid_mask,
                                         input logic [BA_BITS-1:0]   ptr,
                                         input int unsigned          num_banks);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < MAX_BANKS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= num_banks) idx = idx - num_banks;
            if ((k < num_banks) && !res.found && valid_mask[idx[BA_BITS-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[BA_BITS-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/issue_cmd_arbiter_fifo.sv
// Command FIFO between the bank arbiter and the scheduler; head reads as zero when empty.
// Simultaneous push and pop are allowed while full.
module issue_cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 22,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             pop_ok, push_ok;

    assign empty  = (count_q == '0);
    assign pop_ok = pop && !empty;
    assign push_ok = push && (!full_q || pop_ok);

    always_comb begin
        mem_d = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/issue_cmd_arbiter.sv
// Arbitrates per-bank command requests (refresh first, then round-robin) into one FIFO.
// NOP requests are granted only when nothing else is eligible, and are dropped.
module issue_cmd_arbiter
    import issue_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BANKS-1:0] req_valid,
    input  issue_fifo_cmd_in_t req_cmd [NUM_BANKS],
    output logic [NUM_BANKS-1:0] req_grant,
    output logic               out_valid,
    output issue_fifo_cmd_in_t out_cmd,
    input  logic               out_ready,
    output logic               fifo_full,
    output logic [CNT_W-1:0]   fifo_count,
    output logic               nop_drop
);

    logic [NUM_BANKS-1:0]   elig_mask, ref_mask, nop_mask;
    logic [BA_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic                   nop_drop_q, nop_drop_d;
    logic                   ref_found;
    logic [BA_BITS-1:0]     ref_idx;
    rr_pick_t               elig_pick, nop_pick;
    logic                   space, push;
    logic [ISSUE_CMD_W-1:0] push_data, fifo_dout;
    logic                   fifo_empty;

    always_comb begin
        elig_mask = '0;
        ref_mask  = '0;
        nop_mask  = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            elig_mask[i] = req_valid[i] && (req_cmd[i].command != ATCMD_NOP);
            ref_mask[i]  = elig_mask[i] && (req_cmd[i].command == ATCMD_REFRESH);
            nop_mask[i]  = req_valid[i] && (req_cmd[i].command == ATCMD_NOP);
        end
    end

    always_comb begin
        ref_found = 1'b0;
        ref_idx   = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (ref_mask[i] && !ref_found) begin
                ref_found = 1'b1;
                ref_idx   = BA_BITS'(i);
            end
        end
    end

    assign elig_pick = rr_pick(MAX_BANKS'(elig_mask), rr_ptr_q, NUM_BANKS);
    assign nop_pick  = rr_pick(MAX_BANKS'(nop_mask), rr_ptr_q, NUM_BANKS);
    // A full FIFO can still take a write when the head leaves at the same edge.
    assign space     = !fifo_full || (out_valid && out_ready);

    always_comb begin
        req_grant  = '0;
        push       = 1'b0;
        push_data  = '0;
        nop_drop_d = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        if (rst_n) begin
            if (ref_found) begin
                if (space) begin
                    req_grant = NUM_BANKS'(1) << ref_idx;
                    push      = 1'b1;
                    push_data = req_cmd[ref_idx];
                end
            end else if (elig_pick.found) begin
                if (space) begin
                    req_grant = NUM_BANKS'(1) << elig_pick.idx;
                    push      = 1'b1;
                    push_data = req_cmd[elig_pick.idx];
                    rr_ptr_d  = (elig_pick.idx == BA_BITS'(NUM_BANKS - 1)) ? '0 : elig_pick.idx + 1'b1;
                end
            end else if (nop_pick.found) begin
                req_grant  = NUM_BANKS'(1) << nop_pick.idx;
                nop_drop_d = 1'b1;
                rr_ptr_d   = (nop_pick.idx == BA_BITS'(NUM_BANKS - 1)) ? '0 : nop_pick.idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            nop_drop_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            nop_drop_q <= nop_drop_d;
        end
    end

    issue_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (ISSUE_CMD_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (out_ready),
        .din   (push_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_cmd   = issue_fifo_cmd_in_t'(fifo_dout);
    assign nop_drop  = nop_drop_q;

endmodule

// File: tb/tb_issue_cmd_arbiter.sv
// Directed and scoreboard-checked stimulus for issue_cmd_arbiter.
module tb_issue_cmd_arbiter;
    import issue_cmd_arbiter_pkg::*;

    localparam int unsigned NB    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NB-1:0]      req_valid;
    issue_fifo_cmd_in_t req_cmd [NB];
    logic [NB-1:0]      req_grant;
    logic               out_valid;
    issue_fifo_cmd_in_t out_cmd;
    logic               out_ready;
    logic               fifo_full;
    logic [CNT_W-1:0]   fifo_count;
    logic               nop_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_cmd_arbiter #(
        .NUM_BANKS (NB),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_grant  (req_grant),
        .out_valid  (out_valid),
        .out_cmd    (out_cmd),
        .out_ready  (out_ready),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .nop_drop   (nop_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int b, input sch_cmd_t c, input logic [15:0] a);
        req_valid[b] = 1'b1;
        req_cmd[b]   = '{command: c, addr: a, bank: 3'(b)};
    endtask

    task automatic clr_req();
        req_valid = '0;
        for (int i = 0; i < NB; i++) req_cmd[i] = '{command: ATCMD_NOP, addr: '0, bank: '0};
    endtask

    issue_fifo_cmd_in_t sb_q[$];
    int unsigned        m_rr;
    logic               m_nop_prev;

    initial begin
        out_ready = 1'b0;
        rst_n     = 1'b0;
        clr_req();
        for (int i = 0; i < NB; i++) set_req(i, ATCMD_ACTIVE, 16'(i));
        tick();
        tick();
        chk("rst_grant", 32'(req_grant), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_nop_drop", 32'(nop_drop), 32'd0);
        chk("rst_out_cmd", 32'(out_cmd), 32'h0);
        clr_req();
        rst_n = 1'b1;
        tick();

        // Round-robin across all banks; granted bank drops for one cycle
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            clr_req();
            for (int i = 0; i < NB; i++) set_req(i, ATCMD_ACTIVE, 16'(i));
            if (k > 0) req_valid[(k - 1) % 8] = 1'b0;
            #1;
            chk("rr_grant", 32'(req_grant), 32'(1 << (k % 8)));
            if (k > 0) begin
                chk("rr_head_valid", 32'(out_valid), 32'd1);
                chk("rr_head_bank", 32'(out_cmd.bank), 32'((k - 1) % 8));
            end
            tick();
        end
        clr_req();
        #1;
        chk("rr_last_head", 32'(out_cmd.bank), 32'd0);
        tick();
        chk("rr_drained", 32'(fifo_count), 32'd0);

        // Move rr_ptr to 3, then refresh priority
        set_req(2, ATCMD_ACTIVE, 16'h22);
        #1;
        chk("rr_to3_grant", 32'(req_grant), 32'h04);
        tick();
        clr_req();
        set_req(2, ATCMD_REFRESH, 16'h2);
        set_req(5, ATCMD_REFRESH, 16'h5);
        set_req(4, ATCMD_READ, 16'h4);
        #1;
        chk("ref_grant2", 32'(req_grant), 32'h04);
        chk("ref_rr3a", 32'(dut.rr_ptr_q), 32'd3);
        tick();
        req_valid[2] = 1'b0;
        #1;
        chk("ref_grant5", 32'(req_grant), 32'h20);
        chk("ref_rr3b", 32'(dut.rr_ptr_q), 32'd3);
        tick();
        req_valid[5] = 1'b0;
        #1;
        chk("ref_grant4", 32'(req_grant), 32'h10);
        chk("ref_rr3c", 32'(dut.rr_ptr_q), 32'd3);
        tick();
        clr_req();
        #1;
        chk("ref_rr5", 32'(dut.rr_ptr_q), 32'd5);
        tick();
        chk("ref_drained", 32'(fifo_count), 32'd0);

        // Fill without drain, then pop and push at the same edge while full
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clr_req();
            set_req(1, ATCMD_ACTIVE, 16'(k));
            #1;
            chk("full_fill_grant", 32'(req_grant), 32'h02);
            tick();
        end
        clr_req();
        set_req(1, ATCMD_ACTIVE, 16'd8);
        #1;
        chk("full_flag", 32'(fifo_full), 32'd1);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_block", 32'(req_grant), 32'h0);
        tick();
        chk("full_still_block", 32'(req_grant), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("full_ready_grant", 32'(req_grant), 32'h02);
        chk("full_head0", 32'(out_cmd.addr), 32'd0);
        tick();
        chk("full_count_hold", 32'(fifo_count), 32'd8);
        chk("full_flag_hold", 32'(fifo_full), 32'd1);
        clr_req();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("full_drain_order", 32'(out_cmd.addr), 32'(k + 1));
            tick();
        end
        chk("full_empty_count", 32'(fifo_count), 32'd0);
        chk("full_empty_valid", 32'(out_valid), 32'd0);
        chk("full_empty_cmd", 32'(out_cmd), 32'h0);

        // Lone NOP request is granted and dropped
        set_req(6, ATCMD_NOP, 16'h66);
        #1;
        chk("nop_grant", 32'(req_grant), 32'h40);
        tick();
        clr_req();
        #1;
        chk("nop_pulse", 32'(nop_drop), 32'd1);
        chk("nop_count", 32'(fifo_count), 32'd0);
        chk("nop_valid", 32'(out_valid), 32'd0);
        tick();
        chk("nop_pulse_end", 32'(nop_drop), 32'd0);

        // Reset with five entries buffered and rr_ptr at 4
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            clr_req();
            set_req(3, ATCMD_ACTIVE, 16'(k + 1));
            #1;
            chk("mid_fill_grant", 32'(req_grant), 32'h08);
            tick();
        end
        clr_req();
        #1;
        chk("mid_count5", 32'(fifo_count), 32'd5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_count0", 32'(fifo_count), 32'd0);
        chk("mid_valid0", 32'(out_valid), 32'd0);
        chk("mid_cmd0", 32'(out_cmd), 32'h0);
        set_req(0, ATCMD_ACTIVE, 16'h100);
        set_req(5, ATCMD_ACTIVE, 16'h105);
        #1;
        chk("mid_rr_from0", 32'(req_grant), 32'h01);
        tick();

        // Random interleave against a scoreboard
        clr_req();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_rr       = 0;
        m_nop_prev = 1'b0;
        for (int c = 0; c < 300; c++) begin
            logic [NB-1:0]      elig, refm, nopm, exp_g;
            logic               space, do_push, do_nop, ref_hit;
            int unsigned        win;
            int unsigned        r;
            rr_pick_t           p;
            sch_cmd_t           cmd;
            clr_req();
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r = $urandom_range(0, 7);
                    case (r)
                        0:       cmd = ATCMD_NOP;
                        1:       cmd = ATCMD_REFRESH;
                        2, 3:    cmd = ATCMD_READ;
                        4, 5:    cmd = ATCMD_WRITE;
                        default: cmd = ATCMD_ACTIVE;
                    endcase
                    set_req(i, cmd, 16'($urandom));
                end
            end
            out_ready = (c < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            #1;
            elig = '0; refm = '0; nopm = '0;
            for (int i = 0; i < NB; i++) begin
                elig[i] = req_valid[i] && (req_cmd[i].command != ATCMD_NOP);
                refm[i] = elig[i] && (req_cmd[i].command == ATCMD_REFRESH);
                nopm[i] = req_valid[i] && (req_cmd[i].command == ATCMD_NOP);
            end
            space   = (sb_q.size() < DEPTH) || (sb_q.size() > 0 && out_ready);
            exp_g   = '0;
            do_push = 1'b0;
            do_nop  = 1'b0;
            win     = 0;
            ref_hit = 1'b0;
            for (int i = NB - 1; i >= 0; i--) if (refm[i]) begin ref_hit = 1'b1; win = i; end
            if (ref_hit) begin
                if (space) do_push = 1'b1;
            end else if (elig != '0) begin
                p = rr_pick(elig, 3'(m_rr), NB);
                win = p.idx;
                if (space) begin
                    do_push = 1'b1;
                    m_rr    = (win == NB - 1) ? 0 : win + 1;
                end
            end else if (nopm != '0) begin
                p = rr_pick(nopm, 3'(m_rr), NB);
                win    = p.idx;
                do_nop = 1'b1;
                m_rr   = (win == NB - 1) ? 0 : win + 1;
            end
            if (do_push || do_nop) exp_g = NB'(1) << win;
            chk("rnd_grant", 32'(req_grant), 32'(exp_g));
            chk("rnd_count", 32'(fifo_count), 32'(sb_q.size()));
            chk("rnd_valid", 32'(out_valid), 32'(sb_q.size() != 0));
            chk("rnd_nop_drop", 32'(nop_drop), 32'(m_nop_prev));
            if (sb_q.size() != 0) chk("rnd_head", 32'(out_cmd), 32'(sb_q[0]));
            if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
            if (do_push) sb_q.push_back(req_cmd[win]);
            m_nop_prev = do_nop;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_cmd_arbiter.md
# issue_cmd_arbiter

Collects per-bank command requests from the bank FSMs and arbitrates them into a single ordered command stream for the command scheduler. Each bank FSM presents one `issue_fifo_cmd_in_t` at a time. A round-robin arbiter with refresh priority grants at most one request per cycle. Granted commands are buffered in a small FIFO that the scheduler drains through a valid/ready handshake.

## Interface
Parameters:
- `NUM_BANKS`, default 8: number of requesting bank FSMs, which equals the number of banks addressed by `BA_BITS`.
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `req_valid`, input, `NUM_BANKS`: bank i holds a request.
- `req_cmd`, input, `NUM_BANKS` x `issue_fifo_cmd_in_t`: request payload per bank.
- `req_grant`, output, `NUM_BANKS`: one-hot or zero, combinational. The grant is taken at the same edge it is asserted.
- `out_valid`, output, 1: the FIFO head is valid.
- `out_cmd`, output, `issue_fifo_cmd_in_t`: FIFO head.
- `out_ready`, input, 1: the scheduler accepts the head this cycle.
- `fifo_full`, output, 1: registered full flag.
- `fifo_count`, output, `CNT_W`: registered occupancy.
- `nop_drop`, output, 1: one-cycle pulse when a NOP request was discarded.

## Operation
- **Eligibility.** A bank is eligible when `req_valid[i]=1` and `req_cmd[i].command != ATCMD_NOP`.
- **NOP requests.**
  - A valid request carrying `ATCMD_NOP` is granted only when no eligible request exists.
  - That grant follows the same round-robin order and does not write the FIFO.
  - It pulses `nop_drop` in the next cycle.
- **Refresh priority.**
  - If any eligible request has `command == ATCMD_REFRESH`, the lowest-index such bank wins.
  - The round-robin pointer is unchanged.
- **Round-robin.**
  - Otherwise the winner is the first eligible bank at or after `rr_ptr`, wrapping modulo `NUM_BANKS`.
  - After the grant, `rr_ptr` becomes winner+1, wrapping to 0 after `NUM_BANKS-1`.
- **Space check.** A grant for a FIFO write requires that the FIFO is not full, or that it is full and `out_valid && out_ready` in the same cycle.
- **Blocked requests.** A request that is not granted is held by its bank unchanged. The arbiter stores nothing for ungranted requests.
- **FIFO write.** The granted payload is written at `wr_ptr` at the clock edge.
- **FIFO read.** A pop occurs when `out_valid && out_ready`. `rd_ptr` advances at the same edge.
- **Output when empty.** `out_cmd` shows the entry at `rd_ptr` when `out_valid=1`. When empty it is all-zero, which is `ATCMD_NOP`, addr 0, bank 0.
- **Reset values.**
  - Pointers, `rr_ptr` and count are 0.
  - `out_valid`, `fifo_full` and `nop_drop` are 0.
  - `req_grant` is 0 during reset.
  - Reset mid-operation discards all buffered entries. Banks holding requests re-arbitrate starting from bank 0.

## Timing
- **Grant.** `req_grant` is combinational from `req_valid`, `req_cmd`, registered FIFO state and `out_ready`, with zero-cycle latency.
- **Push to head.** A command granted in cycle N is visible on `out_cmd` with `out_valid=1` in cycle N+1 at the earliest, when the FIFO was empty. There is no bypass path.
- **Throughput.** One grant and one pop per cycle are sustainable indefinitely.
- **Count arithmetic.**
  - Push only: +1.
  - Pop only: −1.
  - Both, or neither: unchanged.
  - `fifo_full = (count == DEPTH)`.
  - Pointers are `log2(DEPTH)` bits and wrap naturally.
- **Empty FIFO with `out_ready=1`.** No pop occurs and count does not underflow.
- **Full FIFO with `out_ready=1`.** A grant is allowed and count stays at `DEPTH`.
- **Full FIFO with `out_ready=0`.** No FIFO-write grant is issued. A NOP-only request may still be granted and dropped.

## Structure
- `usertype` package additions:
  - `localparam ISSUE_CMD_W = $bits(issue_fifo_cmd_in_t)`.
  - A function `rr_pick(valid_mask, ptr)` returning the winner index and a found flag. The bench reuses it.
- Reused unchanged: `sch_cmd_t` and `issue_fifo_cmd_in_t`.
- Sub-module `issue_cmd_fifo`:
  - Parameterised storage over `DEPTH` and `ISSUE_CMD_W`, with ports push/pop/din/dout/count/full/empty.
  - The arbiter top instantiates it once and contains the arbitration logic plus `rr_ptr`.

## Test plan
- **Round-robin.** After reset, `req_valid=8'hFF`, all `ATCMD_ACTIVE`, with `out_ready=1`, and each bank drops its request for one cycle once granted. Required: grants go in order 0,1,…,7,0. `out_cmd.bank` follows the same sequence one cycle later.
- **Refresh priority.** `rr_ptr=3`; banks 2 and 5 hold `ATCMD_REFRESH`, bank 4 holds `ATCMD_READ`. Required: bank 2 is granted, then bank 5, then bank 4. `rr_ptr` stays 3 until bank 4 is granted, then becomes 5.
- **Full without drain.** `out_ready=0`, 9 ACTIVE requests from bank 1. Required: 8 grants, then `fifo_full=1` and `fifo_count=8`. The ninth request is held with no grant until `out_ready=1`, then is granted in that same cycle with count staying at 8.
- **NOP handling.** Bank 6 holds `ATCMD_NOP` alone. Required: it is granted, `nop_drop` pulses in the next cycle, `fifo_count` stays 0 and `out_valid` stays 0.
- **Reset mid-operation.** Hold `rst_n=0` for one cycle with 5 entries buffered. Required: the next cycle shows count 0, `out_valid=0`, `out_cmd` all zero, and the next grant starts round-robin from bank 0.
- **Random interleave.** Random valid/ready, checked against a scoreboard model. Required: FIFO order is preserved, count never exceeds `DEPTH`, and no command is lost or duplicated.
